// File: rtl/neuron_input_loader_if.sv
// Stream handshake bundle feeding neuron_input_loader.
// The source drives valid/data/last; the loader returns ready.
interface neuron_input_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/neuron_input_loader.sv
// neuron_input_loader: assembles a serial stream of activations into a
// double-buffered N_INPUTS-word vector for the neuron's parallel input bus,
// and emits out_valid aligned with the neuron's result.
// Optional feature macro: NEURON_LOADER_FRAME_CHECK_EN (s_last framing checks,
// err_short / err_long pulses, DRAIN state). Default build ignores s_last.
module neuron_input_loader #(
  parameter int N_INPUTS       = 64,
  parameter int DATA_W         = 32,
  parameter int NEURON_LATENCY = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  neuron_input_loader_if.slave               stream,
  input  logic                               launch_en,
  output logic [N_INPUTS-1:0][DATA_W-1:0]    vec_out,
  output logic                               vec_valid,
  output logic                               out_valid,
  output logic                               err_short,
  output logic                               err_long,
  output logic [15:0]                        frame_cnt
);

  localparam int                IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);

`ifdef NEURON_LOADER_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               drain_pending, drain_pending_n;
  logic               commit;
  logic               commit_fill;
  logic               err_short_n, err_long_n;
  logic               xfer;
  logic [DATA_W-1:0]  shadow [N_INPUTS];
  logic [NEURON_LATENCY-1:0] delay_sr;

  assign xfer      = stream.s_valid && stream.s_ready;
  assign out_valid = delay_sr[NEURON_LATENCY-1];

  // Next-state, index and commit decisions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_n         = state;
    idx_n           = idx;
    drain_pending_n = drain_pending;
    commit          = 1'b0;
    commit_fill     = 1'b0;
    err_short_n     = 1'b0;
    err_long_n      = 1'b0;
    case (state)
      FILL: begin
        if (xfer) begin
          if (FRAME_CHECK && stream.s_last && (idx != LAST_IDX)) begin
            // Early end of frame: drop the partial vector and restart.
            err_short_n = 1'b1;
            idx_n       = '0;
          end else if (idx == LAST_IDX) begin
            idx_n      = '0;
            err_long_n = FRAME_CHECK && !stream.s_last;
            if (launch_en) begin
              commit      = 1'b1;
              commit_fill = 1'b1;
              state_n     = err_long_n ? DRAIN : FILL;
            end else begin
              state_n         = FULL;
              drain_pending_n = err_long_n;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      FULL: begin
        if (launch_en) begin
          commit          = 1'b1;
          state_n         = drain_pending ? DRAIN : FILL;
          drain_pending_n = 1'b0;
        end
      end
      DRAIN: begin
        // Swallow the overlong frame's tail up to its s_last.
        if (xfer && stream.s_last) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  // Control state register; s_ready is registered and follows the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      idx            <= '0;
      drain_pending  <= 1'b0;
      stream.s_ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state          <= state_n;
      idx            <= idx_n;
      drain_pending  <= drain_pending_n;
      stream.s_ready <= (state_n != FULL);
    end
  end

  // Shadow buffer write; only FILL stores words.
  // NOTE: the shadow memory has no reset; idx restarts at 0 so every word is rewritten before any commit reads it.
  always_ff @(posedge clk) begin
    if (xfer && (state == FILL)) shadow[idx] <= stream.s_data;
  end

  // Active vector, pulses, frame counter and the out_valid delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out   <= '0;
      vec_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      frame_cnt <= '0;
      delay_sr  <= '0;
    end else begin
      vec_valid <= commit;
      err_short <= err_short_n;
      err_long  <= err_long_n;
      delay_sr  <= NEURON_LATENCY'({delay_sr, vec_valid});
      if (commit) begin
        frame_cnt <= frame_cnt + 16'd1;
        for (int i = 0; i < N_INPUTS; i++) vec_out[i] <= shadow[i];
        // Committing on the last word's edge: that word bypasses the shadow.
        if (commit_fill) vec_out[N_INPUTS-1] <= stream.s_data;
      end
    end
  end

endmodule

// File: tb/tb_neuron_input_loader.sv
// Scoreboard bench for neuron_input_loader: the stimulus pushes expected
// vectors, a negedge monitor pops and compares on vec_valid / out_valid.
module tb_neuron_input_loader;
  localparam int N = 64;
  localparam int W = 32;
  localparam int L = 5;

`ifdef NEURON_LOADER_FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t        v;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        launch_en = 1'b1;
  vec_t        vec_out;
  logic        vec_valid, out_valid, err_short, err_long;
  logic [15:0] frame_cnt;

  neuron_input_loader_if #(.DATA_W(W)) bus ();

  neuron_input_loader #(.N_INPUTS(N), .DATA_W(W), .NEURON_LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (bus),
    .launch_en (launch_en),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .out_valid (out_valid),
    .err_short (err_short),
    .err_long  (err_long),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb_q[$];
  int   ov_q[$];
  int   vv_cyc[$];
  int   err_short_seen = 0, err_long_seen = 0, ov_seen = 0;
  int   exp_err_short = 0, exp_err_long = 0;
  vec_t model_v = '0;
  vec_t hold_ref = '0;
  vec_t zero_vec = '0;
  logic [15:0] model_cnt = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    int k;
    k = -1;
    for (int i = 0; i < N; i++) if (k < 0 && act[i] !== exp[i]) k = i;
    if (k < 0) k = 0;
    check($sformatf("%s[%0d]", name, k), 64'(act[k]), 64'(exp[k]));
  endtask

  // Monitor: compare every vec_valid against the scoreboard, time out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vec_valid) begin
        vv_cyc.push_back(cyc);
        check("vec_valid has pending frame", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_vec("vec_out", vec_out, e.v);
          check("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
        end
        ov_q.push_back(cyc + L);
      end
      if (out_valid) begin
        ov_seen++;
        check("out_valid expected", 64'(ov_q.size() != 0), 64'd1);
        if (ov_q.size() != 0) check("out_valid cycle", 64'(cyc), 64'(ov_q.pop_front()));
      end
      if (err_short) err_short_seen++;
      if (err_long)  err_long_seen++;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("s_ready within wait budget", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Sends n words first + step*i; s_last on index last_at. The model
  // predicts commits; stall holds launch_en low for the last word.
  task automatic send_frame(input logic [31:0] first, input logic [31:0] step,
                            input int n, input int last_at, input bit stall);
    int wi;
    wi = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      logic        last;
      d    = first + step * i;
      last = (i == last_at);
      if (i == 32) check_vec("vec_out held", vec_out, hold_ref);
      if (CHECK && last && wi < N - 1) begin
        exp_err_short++;
        wi = -1;
      end else if (wi >= 0 && wi < N) begin
        model_v[wi] = d;
        if (wi == N - 1) begin
          model_cnt++;
          sb_q.push_back('{v: model_v, cnt: model_cnt});
          hold_ref = model_v;
          if (CHECK && !last) exp_err_long++;
        end
      end
      if (stall && i == N - 1) launch_en = 1'b0;
      send_word(d, last);
      if (stall && i == N - 1) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("s_ready low while FULL", 64'(bus.s_ready), 64'd0);
        end
        launch_en = 1'b1;
      end
      wi++;
    end
  endtask

  initial begin
    int ov_before;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset s_ready", 64'(bus.s_ready), 64'd0);
    check("reset vec_valid", 64'(vec_valid), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset err_short", 64'(err_short), 64'd0);
    check("reset err_long", 64'(err_long), 64'd0);
    check("reset frame_cnt", 64'(frame_cnt), 64'd0);
    check_vec("reset vec_out", vec_out, zero_vec);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready after reset release", 64'(bus.s_ready), 64'd1);

    // Words 1..64, s_last on 64.
    send_frame(32'd1, 32'd1, N, N - 1, 1'b0);
    idle();
    repeat (8) @(negedge clk);
    check("frame_cnt after first frame", 64'(frame_cnt), 64'd1);

    // Two back-to-back frames, the second with values -1..-64.
    send_frame(32'h1100_0000, 32'd1, N, N - 1, 1'b0);
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, N, N - 1, 1'b0);
    idle();
    repeat (8) @(negedge clk);
    check("back-to-back spacing", 64'(vv_cyc[vv_cyc.size()-1] - vv_cyc[vv_cyc.size()-2]), 64'd64);

    // launch_en low on word 64, released 10 cycles later; next frame queued.
    send_frame(32'd100, 32'd1, N, N - 1, 1'b1);
    send_frame(32'd200, 32'd1, N, N - 1, 1'b0);
    idle();
    repeat (8) @(negedge clk);

`ifdef NEURON_LOADER_FRAME_CHECK_EN
    // s_last on word 30: error pulse, no commit, then a good frame.
    send_frame(32'd500, 32'd1, 30, 29, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    check_vec("vec_out after short frame", vec_out, hold_ref);
    check("err_short pulses", 64'(err_short_seen), 64'(exp_err_short));
    send_frame(32'd600, 32'd1, N, N - 1, 1'b0);
    idle();
    repeat (8) @(negedge clk);
    // 70 words, s_last on 70: commit after 64, tail dropped.
    send_frame(32'd700, 32'd1, 70, 69, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    check("err_long pulses", 64'(err_long_seen), 64'(exp_err_long));
    send_frame(32'd800, 32'd1, N, N - 1, 1'b0);
    idle();
    repeat (8) @(negedge clk);
`endif

    // Reset inside the out_valid window with a partial frame in progress.
    send_frame(32'd300, 32'd1, N, N - 1, 1'b0);
    send_word(32'd999, 1'b0);
    send_word(32'd998, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    #1;
    check("async reset s_ready", 64'(bus.s_ready), 64'd0);
    check("async reset vec_valid", 64'(vec_valid), 64'd0);
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset frame_cnt", 64'(frame_cnt), 64'd0);
    check_vec("async reset vec_out", vec_out, zero_vec);
    ov_q.delete();
    model_cnt = '0;
    model_v   = '0;
    hold_ref  = '0;
    ov_before = ov_seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no out_valid after reset", 64'(ov_seen - ov_before), 64'd0);
    send_frame(32'hA000_0000, 32'd1, N, N - 1, 1'b0);
    idle();

    repeat (20) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    check("out_valid queue drained", 64'(ov_q.size()), 64'd0);
    check("err_short total", 64'(err_short_seen), 64'(exp_err_short));
    check("err_long total", 64'(err_long_seen), 64'(exp_err_long));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
